// File: rtl/spi_slave_rx32_if.sv
// Bus bundle for spi_slave_rx32: SPI pins, reply/receive words and status.
`timescale 1ns/1ps
interface spi_slave_rx32_if #(
  parameter int FRAME_BITS = 32,
  parameter int ERRCNT_W   = 8
);
  // rx_valid and frame_err are single-cycle strobes with no ready: the SPI
  // master cannot be stalled, so a consumer must take rx_data when rx_valid=1.
  logic                  en;
  logic                  SCK;
  logic                  SSEL;
  logic                  MOSI;
  logic                  MISO;
  logic [FRAME_BITS-1:0] tx_data;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic                  frame_err;
  logic [ERRCNT_W-1:0]   err_count;
  logic                  busy;
  logic [1:0]            state_dbg;

  modport slave (
    input  en, SCK, SSEL, MOSI, tx_data,
    output MISO, rx_data, rx_valid, frame_err, err_count, busy, state_dbg
  );

  modport master (
    output en, SCK, SSEL, MOSI, tx_data,
    input  MISO, rx_data, rx_valid, frame_err, err_count, busy, state_dbg
  );
endinterface

// File: rtl/spi_slave_rx32.sv
// SPI slave for fixed-length frames: oversamples SCK/SSEL/MOSI in clk,
// assembles the received word and shifts a reply word out on MISO.
`timescale 1ns/1ps
module spi_slave_rx32 #(
  parameter int FRAME_BITS  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ERRCNT_W    = 8
) (
  input  logic           clk,
  input  logic           reset,
  spi_slave_rx32_if.slave bus
);
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam int FL_W  = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync, ssel_sync, mosi_sync;
  logic                   sck_hist, ssel_hist;
  logic                   sck_s, ssel_s, mosi_s;
  logic                   sck_rise, sck_fall, ssel_rise, ssel_fall;
  logic [FL_W-1:0]        flush_cnt;
  logic                   flush_done, ssel_armed;

  logic [FRAME_BITS-1:0]  tx_shift, rx_shift;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   over_len;
  logic                   miso_q;
  logic                   frame_ok;

  logic start, rx_step, ovf_set, tx_step, commit, abort, miso_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync  <= '0;
      ssel_sync <= '1;
      mosi_sync <= '0;
      sck_hist  <= 1'b0;
      ssel_hist <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.SCK};
      ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], bus.SSEL};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
      sck_hist  <= sck_sync[SYNC_STAGES-1];
      ssel_hist <= ssel_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ssel_s = ssel_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // The chains reset to "idle" values, so a falling SSEL is only trusted once
  // a genuinely sampled high level has been seen after reset.
  assign flush_done = (flush_cnt == FL_W'(SYNC_STAGES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt  <= '0;
      ssel_armed <= 1'b0;
    end else begin
      if (!flush_done) flush_cnt <= flush_cnt + FL_W'(1);
      ssel_armed <= ssel_armed | (flush_done & ssel_s);
    end
  end

  assign sck_rise  = sck_s & ~sck_hist;
  assign sck_fall  = ~sck_s & sck_hist;
  assign ssel_rise = ssel_s & ~ssel_hist;
  assign ssel_fall = ssel_armed & ssel_hist & ~ssel_s;

  assign frame_ok = (bit_cnt == CNT_W'(FRAME_BITS)) && !over_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    rx_step  = 1'b0;
    ovf_set  = 1'b0;
    tx_step  = 1'b0;
    commit   = 1'b0;
    abort    = 1'b0;
    miso_clr = 1'b0;
    case (state_q)
      IDLE: begin
        miso_clr = 1'b1;
        if (bus.en && ssel_fall) begin
          state_d  = ACTIVE;
          start    = 1'b1;
          miso_clr = 1'b0;
        end
      end
      ACTIVE: begin
        if (!bus.en) begin
          state_d  = IDLE;
          miso_clr = 1'b1;
        end else if (ssel_rise) begin
          // SSEL rising wins over a coincident SCK edge.
          state_d = DONE;
        end else begin
          if (sck_rise) begin
            if (bit_cnt == CNT_W'(FRAME_BITS)) ovf_set = 1'b1;
            else                               rx_step = 1'b1;
          end
          tx_step = sck_fall;
        end
      end
      DONE: begin
        state_d  = IDLE;
        miso_clr = 1'b1;
        if (bus.en) begin
          commit = frame_ok;
          abort  = !frame_ok;
        end
      end
      default: begin
        state_d  = IDLE;
        miso_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_shift      <= '0;
      rx_shift      <= '0;
      bit_cnt       <= '0;
      over_len      <= 1'b0;
      miso_q        <= 1'b0;
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.err_count <= '0;
    end else begin
      bus.rx_valid  <= commit;
      bus.frame_err <= abort;
      if (start) begin
        tx_shift <= bus.tx_data;
        rx_shift <= '0;
        bit_cnt  <= '0;
        over_len <= 1'b0;
        miso_q   <= bus.tx_data[FRAME_BITS-1];
      end else if (miso_clr) begin
        miso_q <= 1'b0;
      end
      if (rx_step) begin
        rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s};
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end
      if (ovf_set) over_len <= 1'b1;
      // Zeros shift in behind the reply word, so MISO falls to 0 after the last bit.
      if (tx_step) begin
        tx_shift <= tx_shift << 1;
        miso_q   <= tx_shift[FRAME_BITS-2];
      end
      if (commit) bus.rx_data <= rx_shift;
      if (abort && (bus.err_count != '1)) bus.err_count <= bus.err_count + ERRCNT_W'(1);
    end
  end

  assign bus.MISO      = miso_q & bus.en;
  assign bus.busy      = (state_q != IDLE);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_spi_slave_rx32.sv
// Directed bench for spi_slave_rx32: a bit-banged SPI master, a frame table
// and hand-written corner sequences (en drop, SSEL low at reset, saturation, async reset).
`timescale 1ns/1ps
module tb_spi_slave_rx32;
  localparam int HALF = 5;
  localparam int LAT  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  spi_slave_rx32_if #(.FRAME_BITS(32), .ERRCNT_W(8)) bus();

  spi_slave_rx32 #(.FRAME_BITS(32), .SYNC_STAGES(2), .ERRCNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tx;
    logic [31:0] mosi;
    int          nbits;
    logic        exp_valid;
    logic [31:0] exp_rx;
    logic [7:0]  exp_errcnt;
    logic [31:0] exp_miso;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          valid_seen = 0;
  int          err_seen   = 0;

  always @(negedge clk) begin
    if (bus.rx_valid)  valid_seen <= valid_seen + 1;
    if (bus.frame_err) err_seen   <= err_seen + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic m);
    bus.MOSI = b;
    wait_clk(HALF);
    bus.SCK = 1'b1;
    m = bus.MISO;
    wait_clk(HALF);
    bus.SCK = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] tx, input logic [31:0] mosi, input int nbits,
                           output logic [31:0] miso_word, output int lat);
    logic        m;
    logic [31:0] sh;
    sh = mosi;
    miso_word = '0;
    lat = 0;
    bus.tx_data = tx;
    bus.SSEL = 1'b0;
    wait_clk(HALF + 2);
    for (int i = 0; i < nbits; i++) begin
      send_bit(sh[31], m);
      sh = sh << 1;
      miso_word = {miso_word[30:0], m};
    end
    wait_clk(HALF);
    bus.SSEL = 1'b1;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(posedge clk);
      #1;
      if (bus.rx_valid || bus.frame_err) lat = c;
      if (bus.rx_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_rx: actual=0x%08h required=no rx_valid", bus.rx_data);
        end else begin
          check("sb_rx_data", bus.rx_data, exp_q.pop_front());
        end
      end
    end
    wait_clk(HALF + 2);
  endtask

  task automatic abort_frame();
    bus.SSEL = 1'b0;
    wait_clk(6);
    bus.SSEL = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    logic [31:0] mw;
    logic        m;
    logic [31:0] sh;
    int          lat, v0, e0;

    vecs[0] = '{32'h1234_5678, 32'hA5A5_0F0F, 32, 1'b1, 32'hA5A5_0F0F, 8'd0, 32'h1234_5678};
    vecs[1] = '{32'h0000_0000, 32'hFFFF_FFFF, 32, 1'b1, 32'hFFFF_FFFF, 8'd0, 32'h0000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 32, 1'b1, 32'h0000_0001, 8'd0, 32'hFFFF_FFFF};
    vecs[3] = '{32'hCAFE_F00D, 32'h1357_2468, 20, 1'b0, 32'h0000_0001, 8'd1, 32'h000C_AFEF};
    vecs[4] = '{32'h0F0F_0F0F, 32'h89AB_CDEF, 33, 1'b0, 32'h0000_0001, 8'd2, 32'h1E1E_1E1E};
    vecs[5] = '{32'h55AA_55AA, 32'h0BAD_F00D, 32, 1'b1, 32'h0BAD_F00D, 8'd2, 32'h55AA_55AA};

    bus.en = 1'b1;
    bus.SCK = 1'b0;
    bus.SSEL = 1'b1;
    bus.MOSI = 1'b0;
    bus.tx_data = '0;
    wait_clk(4);
    check("reset rx_data", bus.rx_data, 32'h0);
    check("reset rx_valid", 32'(bus.rx_valid), 32'h0);
    check("reset frame_err", 32'(bus.frame_err), 32'h0);
    check("reset err_count", 32'(bus.err_count), 32'h0);
    check("reset busy", 32'(bus.busy), 32'h0);
    check("reset MISO", 32'(bus.MISO), 32'h0);
    check("reset state", 32'(bus.state_dbg), 32'h0);
    reset = 1'b0;
    wait_clk(10);

    for (int i = 0; i < 6; i++) begin
      v0 = valid_seen;
      e0 = err_seen;
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].exp_rx);
      run_frame(vecs[i].tx, vecs[i].mosi, vecs[i].nbits, mw, lat);
      check($sformatf("v%0d rx_data", i), bus.rx_data, vecs[i].exp_rx);
      check($sformatf("v%0d err_count", i), 32'(bus.err_count), 32'(vecs[i].exp_errcnt));
      check($sformatf("v%0d miso_word", i), mw, vecs[i].exp_miso);
      check($sformatf("v%0d rx_valid pulses", i), 32'(valid_seen - v0), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d frame_err pulses", i), 32'(err_seen - e0), 32'(!vecs[i].exp_valid));
      check($sformatf("v%0d latency", i), 32'(lat), 32'(LAT));
      check($sformatf("v%0d busy", i), 32'(bus.busy), 32'h0);
    end

    // en dropped after bit 10: silent return to IDLE, rest of the frame ignored.
    v0 = valid_seen;
    e0 = err_seen;
    bus.tx_data = 32'hFFFF_FFFF;
    bus.SSEL = 1'b0;
    wait_clk(HALF + 2);
    sh = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      send_bit(sh[31], m);
      sh = sh << 1;
    end
    check("endrop busy before", 32'(bus.busy), 32'h1);
    check("endrop MISO before", 32'(bus.MISO), 32'h1);
    bus.en = 1'b0;
    wait_clk(2);
    check("endrop busy", 32'(bus.busy), 32'h0);
    check("endrop MISO", 32'(bus.MISO), 32'h0);
    check("endrop state", 32'(bus.state_dbg), 32'h0);
    for (int i = 10; i < 32; i++) begin
      send_bit(sh[31], m);
      sh = sh << 1;
    end
    wait_clk(HALF);
    bus.SSEL = 1'b1;
    wait_clk(10);
    check("endrop rx_valid pulses", 32'(valid_seen - v0), 32'h0);
    check("endrop frame_err pulses", 32'(err_seen - e0), 32'h0);
    bus.en = 1'b1;
    wait_clk(4);
    exp_q.push_back(32'hDEAD_BEEF);
    run_frame(32'h600D_F00D, 32'hDEAD_BEEF, 32, mw, lat);
    check("deadbeef rx_data", bus.rx_data, 32'hDEAD_BEEF);
    check("deadbeef err_count", 32'(bus.err_count), 32'd2);
    check("deadbeef miso_word", mw, 32'h600D_F00D);
    check("deadbeef rx_valid pulses", 32'(valid_seen - v0), 32'h1);
    check("deadbeef frame_err pulses", 32'(err_seen - e0), 32'h0);

    // SSEL already low when reset releases: no frame until it goes high then low.
    v0 = valid_seen;
    e0 = err_seen;
    bus.SSEL = 1'b0;
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(6);
    check("ssel_low rx_data after reset", bus.rx_data, 32'h0);
    check("ssel_low err_count after reset", 32'(bus.err_count), 32'h0);
    check("ssel_low busy", 32'(bus.busy), 32'h0);
    sh = 32'h1234_5678;
    for (int i = 0; i < 32; i++) begin
      send_bit(sh[31], m);
      sh = sh << 1;
    end
    check("ssel_low busy after bits", 32'(bus.busy), 32'h0);
    wait_clk(HALF);
    bus.SSEL = 1'b1;
    wait_clk(10);
    check("ssel_low rx_valid pulses", 32'(valid_seen - v0), 32'h0);
    check("ssel_low frame_err pulses", 32'(err_seen - e0), 32'h0);
    check("ssel_low rx_data", bus.rx_data, 32'h0);

    // Error counter saturation.
    e0 = err_seen;
    repeat (255) abort_frame();
    check("sat err_count 255", 32'(bus.err_count), 32'd255);
    abort_frame();
    check("sat err_count held", 32'(bus.err_count), 32'd255);
    check("sat frame_err pulses", 32'(err_seen - e0), 32'd256);
    check("sat rx_data", bus.rx_data, 32'h0);

    exp_q.push_back(32'h0F1E_2D3C);
    run_frame(32'h0, 32'h0F1E_2D3C, 32, mw, lat);
    check("post_sat rx_data", bus.rx_data, 32'h0F1E_2D3C);
    check("post_sat err_count", 32'(bus.err_count), 32'd255);

    // Asynchronous reset in the middle of a frame.
    bus.tx_data = 32'hFFFF_FFFF;
    bus.SSEL = 1'b0;
    wait_clk(HALF + 2);
    for (int i = 0; i < 5; i++) send_bit(1'b1, m);
    check("areset busy before", 32'(bus.busy), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("areset rx_data", bus.rx_data, 32'h0);
    check("areset rx_valid", 32'(bus.rx_valid), 32'h0);
    check("areset frame_err", 32'(bus.frame_err), 32'h0);
    check("areset err_count", 32'(bus.err_count), 32'h0);
    check("areset busy", 32'(bus.busy), 32'h0);
    check("areset MISO", 32'(bus.MISO), 32'h0);
    bus.SSEL = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(8);
    check("areset idle after release", 32'(bus.busy), 32'h0);
    check("sb queue empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
